// File: rtl/spi_master_cs_ctrl.sv
// spi_master_cs_ctrl: transaction front end for a byte-level SPI master engine.
// It accepts a byte count plus a stream of TX bytes and feeds the engine one byte at a time.
// It holds active-low chip-select across the whole transaction, with programmable lead and
// inactive gaps. Each received byte is returned with its 0-based index in the transaction.
// Ports:
//   i_Clk, i_Rst        clock, synchronous active-high reset
//   i_TX_Count          bytes in transaction (sampled with the first accepted byte)
//   i_TX_Byte/i_TX_DV   user TX byte stream, accepted when o_TX_Ready=1
//   o_TX_Ready          ready for the first byte or the next in-flight byte
//   o_RX_DV/Byte/Count  received byte pulse with its index
//   o_CS_n              chip select, active-low
//   o_M_TX_Byte/DV      to engine i_TX_Byte / i_TX_DV
//   i_M_TX_Ready        from engine o_TX_Ready
//   i_M_RX_DV/Byte      from engine o_RX_DV / o_RX_Byte
module spi_master_cs_ctrl #(
  parameter int unsigned MAX_BYTES_PER_CS = 2,
  parameter int unsigned CS_LEAD_CLKS     = 1,
  parameter int unsigned CS_INACTIVE_CLKS = 2,
  localparam int unsigned CNT_W           = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic [CNT_W-1:0] i_TX_Count,
  input  logic [7:0]       i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic [CNT_W-1:0] o_RX_Count,
  output logic             o_RX_DV,
  output logic [7:0]       o_RX_Byte,
  output logic             o_CS_n,
  output logic [7:0]       o_M_TX_Byte,
  output logic             o_M_TX_DV,
  input  logic             i_M_TX_Ready,
  input  logic             i_M_RX_DV,
  input  logic [7:0]       i_M_RX_Byte
);

  // One gap counter serves both the lead and the inactive phases.
  localparam int unsigned GAP_MAX     = (CS_LEAD_CLKS > CS_INACTIVE_CLKS) ? CS_LEAD_CLKS
                                                                           : CS_INACTIVE_CLKS;
  localparam int unsigned GAP_W       = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam int unsigned LEAD_LAST   = (CS_LEAD_CLKS > 0) ? CS_LEAD_CLKS - 1 : 0;
  localparam int unsigned INACT_LAST  = (CS_INACTIVE_CLKS > 0) ? CS_INACTIVE_CLKS - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_INACTIVE
  } state_t;

  state_t           r_State, state_nxt;
  logic [CNT_W-1:0] r_Left, left_nxt;
  logic [CNT_W-1:0] r_RxIdx, rxidx_nxt;
  logic [CNT_W-1:0] r_Count, count_nxt;
  logic [GAP_W-1:0] r_Gap, gap_nxt;
  logic             r_DvDly;
  logic             cs_n_nxt;
  logic [7:0]       m_byte_nxt;
  logic             m_dv_nxt;
  logic             rx_dv_nxt;
  logic [7:0]       rx_byte_nxt;
  logic [CNT_W-1:0] rx_count_nxt;
  logic [CNT_W-1:0] w_Clamped;
  logic             w_Guard;
  logic             w_Accept;
  logic             w_RxLast;

  // Clamp the requested count to the CS window size.
  assign w_Clamped = (i_TX_Count > CNT_W'(MAX_BYTES_PER_CS)) ? CNT_W'(MAX_BYTES_PER_CS)
                                                              : i_TX_Count;

  // Engine ready lags our TX pulse; mask it for the pulse cycle and the one after.
  assign w_Guard = o_M_TX_DV | r_DvDly;

  assign o_TX_Ready = ~i_Rst &
                      ((r_State == ST_IDLE) |
                       ((r_State == ST_XFER) & (r_Left != '0) & i_M_TX_Ready & ~w_Guard));

  assign w_Accept = i_TX_DV & o_TX_Ready;
  assign w_RxLast = (r_RxIdx == (r_Count - CNT_W'(1)));

  // State and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State     <= ST_IDLE;
      r_Left      <= '0;
      r_RxIdx     <= '0;
      r_Count     <= '0;
      r_Gap       <= '0;
      r_DvDly     <= 1'b0;
      o_CS_n      <= 1'b1;
      o_M_TX_Byte <= '0;
      o_M_TX_DV   <= 1'b0;
      o_RX_DV     <= 1'b0;
      o_RX_Byte   <= '0;
      o_RX_Count  <= '0;
    end else begin
      r_State     <= state_nxt;
      r_Left      <= left_nxt;
      r_RxIdx     <= rxidx_nxt;
      r_Count     <= count_nxt;
      r_Gap       <= gap_nxt;
      r_DvDly     <= o_M_TX_DV;
      o_CS_n      <= cs_n_nxt;
      o_M_TX_Byte <= m_byte_nxt;
      o_M_TX_DV   <= m_dv_nxt;
      o_RX_DV     <= rx_dv_nxt;
      o_RX_Byte   <= rx_byte_nxt;
      o_RX_Count  <= rx_count_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt    = r_State;
    left_nxt     = r_Left;
    rxidx_nxt    = r_RxIdx;
    count_nxt    = r_Count;
    gap_nxt      = r_Gap;
    cs_n_nxt     = o_CS_n;
    m_byte_nxt   = o_M_TX_Byte;
    m_dv_nxt     = 1'b0;
    rx_dv_nxt    = 1'b0;
    rx_byte_nxt  = o_RX_Byte;
    rx_count_nxt = o_RX_Count;

    // RX bytes are forwarded in any state; the index saturates instead of wrapping.
    if (i_M_RX_DV) begin
      rx_dv_nxt    = 1'b1;
      rx_byte_nxt  = i_M_RX_Byte;
      rx_count_nxt = r_RxIdx;
      if (r_RxIdx != '1) begin
        rxidx_nxt = r_RxIdx + CNT_W'(1);
      end
    end

    case (r_State)
      ST_IDLE: begin
        if (w_Accept && (i_TX_Count != '0)) begin
          count_nxt  = w_Clamped;
          rxidx_nxt  = '0;
          cs_n_nxt   = 1'b0;
          m_byte_nxt = i_TX_Byte;
          gap_nxt    = '0;
          if (CS_LEAD_CLKS == 0) begin
            m_dv_nxt  = 1'b1;
            left_nxt  = w_Clamped - CNT_W'(1);
            state_nxt = ST_XFER;
          end else begin
            left_nxt  = w_Clamped;
            state_nxt = ST_LEAD;
          end
        end
      end
      ST_LEAD: begin
        if (r_Gap == GAP_W'(LEAD_LAST)) begin
          m_dv_nxt  = 1'b1;
          left_nxt  = r_Left - CNT_W'(1);
          gap_nxt   = '0;
          state_nxt = ST_XFER;
        end else begin
          gap_nxt = r_Gap + GAP_W'(1);
        end
      end
      ST_XFER: begin
        if (w_Accept) begin
          m_byte_nxt = i_TX_Byte;
          m_dv_nxt   = 1'b1;
          left_nxt   = r_Left - CNT_W'(1);
        end
        // Final byte received: release CS and start the inactive gap.
        if (i_M_RX_DV && w_RxLast) begin
          cs_n_nxt  = 1'b1;
          gap_nxt   = '0;
          state_nxt = ST_INACTIVE;
        end
      end
      ST_INACTIVE: begin
        cs_n_nxt = 1'b1;
        if (r_Gap == GAP_W'(INACT_LAST)) begin
          gap_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          gap_nxt = r_Gap + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
